// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: owner IDs tagging
// in-flight reads, bus widths and the grant selector.
package mem_arb_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef logic [1:0] owner_id_t;

  localparam owner_id_t ID_NONE  = 2'd0;
  localparam owner_id_t ID_FETCH = 2'd1;
  localparam owner_id_t ID_LOAD  = 2'd2;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_STORE,
    SEL_LOAD,
    SEL_FETCH
  } grant_sel_e;

  function automatic owner_id_t sel_to_id(input grant_sel_e sel);
    case (sel)
      SEL_FETCH: return ID_FETCH;
      SEL_LOAD:  return ID_LOAD;
      default:   return ID_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The arbiter uses the slave
// view; the pipeline/memory environment uses the master view.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic [ADDR_W-1:0] l_addr;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic              s_req;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              s_gnt;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              starved;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, s_req, s_addr, s_data, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, s_gnt,
           mem_addr, mem_wen, mem_wdata, starved
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, s_req, s_addr, s_data, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, s_gnt,
           mem_addr, mem_wen, mem_wdata, starved
  );

endinterface

// File: rtl/mem_port_arbiter_rsp_tag_pipe.sv
// Fixed-depth shift register of read owner IDs; the last stage names the
// requester that owns the memory read data arriving this cycle.
module rsp_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      i_clr,
  input  owner_id_t i_id,
  output owner_id_t o_id
);

  owner_id_t r_stage [DEPTH];

  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= ID_NONE;
    end else begin
      r_stage[0] <= i_id;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_id = r_stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, load and store with an age counter
// that promotes fetch after STARVE_MAX consecutive denied cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int STARVE_MAX   = 3
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arbiter_if.slave bus
);

  logic [3:0] r_age;
  logic       w_starved;
  grant_sel_e w_sel;
  owner_id_t  w_rsp_id;

  assign w_starved = (r_age == 4'(STARVE_MAX));

  // A starved fetch jumps ahead; otherwise store > load > fetch.
  always_comb begin
    w_sel = SEL_NONE;
    if (!rst) begin
      if (w_starved && bus.f_req) w_sel = SEL_FETCH;
      else if (bus.s_req)         w_sel = SEL_STORE;
      else if (bus.l_req)         w_sel = SEL_LOAD;
      else if (bus.f_req)         w_sel = SEL_FETCH;
    end
  end

  always_comb begin
    bus.f_gnt     = 1'b0;
    bus.l_gnt     = 1'b0;
    bus.s_gnt     = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wen   = 1'b0;
    bus.mem_wdata = '0;
    case (w_sel)
      SEL_STORE: begin
        bus.s_gnt     = 1'b1;
        bus.mem_addr  = bus.s_addr;
        bus.mem_wen   = 1'b1;
        bus.mem_wdata = bus.s_data;
      end
      SEL_LOAD: begin
        bus.l_gnt    = 1'b1;
        bus.mem_addr = bus.l_addr;
      end
      SEL_FETCH: begin
        bus.f_gnt    = 1'b1;
        bus.mem_addr = bus.f_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_age <= '0;
    end else if (!bus.f_req || (w_sel == SEL_FETCH)) begin
      r_age <= '0;
    end else if (!w_starved) begin
      r_age <= r_age + 4'd1;
    end
  end

  // Reset clears the pipe, so reads in flight across a reset never return.
  rsp_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_rsp_tag_pipe (
    .clk   (clk),
    .i_clr (rst),
    .i_id  (sel_to_id(w_sel)),
    .o_id  (w_rsp_id)
  );

  assign bus.f_rvalid = !rst && (w_rsp_id == ID_FETCH);
  assign bus.l_rvalid = !rst && (w_rsp_id == ID_LOAD);
  assign bus.f_rdata  = bus.f_rvalid ? bus.mem_rdata : '0;
  assign bus.l_rdata  = bus.l_rvalid ? bus.mem_rdata : '0;
  assign bus.starved  = !rst && w_starved;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 2 and 3) share one
// stimulus; a behavioural model predicts grants, memory drive and responses.
module tb_mem_port_arbiter;

  localparam int SMAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  logic        f_req, l_req, s_req;
  logic [14:0] f_addr, l_addr, s_addr;
  logic [15:0] s_data;

  int fq[$];
  int lq[$];
  int sqa[$];
  int sqd[$];

  mem_port_arbiter_if bus0();
  mem_port_arbiter_if bus1();

  mem_port_arbiter #(.READ_LATENCY(2), .STARVE_MAX(SMAX)) u_dut0 (
    .clk (clk), .rst (rst), .bus (bus0.slave));
  mem_port_arbiter #(.READ_LATENCY(3), .STARVE_MAX(SMAX)) u_dut1 (
    .clk (clk), .rst (rst), .bus (bus1.slave));

  assign bus0.f_req = f_req;  assign bus1.f_req = f_req;
  assign bus0.f_addr = f_addr; assign bus1.f_addr = f_addr;
  assign bus0.l_req = l_req;  assign bus1.l_req = l_req;
  assign bus0.l_addr = l_addr; assign bus1.l_addr = l_addr;
  assign bus0.s_req = s_req;  assign bus1.s_req = s_req;
  assign bus0.s_addr = s_addr; assign bus1.s_addr = s_addr;
  assign bus0.s_data = s_data; assign bus1.s_data = s_data;

  // Synchronous memories: write at the edge, read data captured at the
  // address edge and delivered after the instance's read latency.
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [15:0] dp0 [2];
  logic [15:0] dp1 [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int a = 0; a < 256; a++) begin
        mem0[a] <= 16'hA000 + 16'(a);
        mem1[a] <= 16'hA000 + 16'(a);
      end
    end else begin
      if (bus0.mem_wen) mem0[bus0.mem_addr[7:0]] <= bus0.mem_wdata;
      if (bus1.mem_wen) mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    end
    dp0[0] <= mem0[bus0.mem_addr[7:0]];
    dp0[1] <= dp0[0];
    dp1[0] <= mem1[bus1.mem_addr[7:0]];
    dp1[1] <= dp1[0];
    dp1[2] <= dp1[1];
  end
  assign bus0.mem_rdata = dp0[1];
  assign bus1.mem_rdata = dp1[2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Model state: denied-fetch age, due-time response slots, shadow memories.
  int          m_age = 0;
  logic        mg_f = 1'b0, mg_l = 1'b0, mg_s = 1'b0;
  logic [14:0] e_addr;
  logic [1:0]  sv [2][8];
  logic [15:0] sd [2][8];
  logic [15:0] sh [2][256];

  function automatic int rl(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  task automatic check_inst(input int k, input logic fg, input logic lg, input logic sg,
                            input logic [14:0] ma, input logic mw, input logic [15:0] mwd,
                            input logic fv, input logic [15:0] fd, input logic lv,
                            input logic [15:0] ld, input logic st);
    int s;
    logic [1:0] o;
    logic [15:0] d;
    s = cyc % 8;
    o = rst ? 2'd0 : sv[k][s];
    d = sd[k][s];
    sv[k][s] = 2'd0;
    chk($sformatf("u%0d_f_gnt", k), fg, mg_f);
    chk($sformatf("u%0d_l_gnt", k), lg, mg_l);
    chk($sformatf("u%0d_s_gnt", k), sg, mg_s);
    chk($sformatf("u%0d_mem_addr", k), ma, e_addr);
    chk($sformatf("u%0d_mem_wen", k), mw, mg_s);
    chk($sformatf("u%0d_mem_wdata", k), mwd, mg_s ? s_data : 16'd0);
    chk($sformatf("u%0d_f_rvalid", k), fv, o == 2'd1);
    chk($sformatf("u%0d_f_rdata", k), fd, (o == 2'd1) ? d : 16'd0);
    chk($sformatf("u%0d_l_rvalid", k), lv, o == 2'd2);
    chk($sformatf("u%0d_l_rdata", k), ld, (o == 2'd2) ? d : 16'd0);
    chk($sformatf("u%0d_starved", k), st, !rst && (m_age == SMAX));
  endtask

  always @(negedge clk) begin
    mg_f = 1'b0; mg_l = 1'b0; mg_s = 1'b0;
    if (!rst) begin
      if (m_age == SMAX && f_req) mg_f = 1'b1;
      else if (s_req)             mg_s = 1'b1;
      else if (l_req)             mg_l = 1'b1;
      else if (f_req)             mg_f = 1'b1;
    end
    e_addr = mg_s ? s_addr : mg_l ? l_addr : mg_f ? f_addr : 15'd0;

    check_inst(0, bus0.f_gnt, bus0.l_gnt, bus0.s_gnt, bus0.mem_addr, bus0.mem_wen,
               bus0.mem_wdata, bus0.f_rvalid, bus0.f_rdata, bus0.l_rvalid,
               bus0.l_rdata, bus0.starved);
    check_inst(1, bus1.f_gnt, bus1.l_gnt, bus1.s_gnt, bus1.mem_addr, bus1.mem_wen,
               bus1.mem_wdata, bus1.f_rvalid, bus1.f_rdata, bus1.l_rvalid,
               bus1.l_rdata, bus1.starved);

    for (int k = 0; k < 2; k++) begin
      if (mem_init)
        for (int a = 0; a < 256; a++) sh[k][a] = 16'hA000 + 16'(a);
      if (rst) begin
        for (int j = 0; j < 8; j++) sv[k][j] = 2'd0;
      end else begin
        if (mg_f || mg_l) begin
          sv[k][(cyc + rl(k)) % 8] = mg_f ? 2'd1 : 2'd2;
          sd[k][(cyc + rl(k)) % 8] = sh[k][e_addr[7:0]];
        end
        if (mg_s) sh[k][s_addr[7:0]] = s_data;
      end
    end
    if (rst || !f_req || mg_f) m_age = 0;
    else if (m_age < SMAX)     m_age = m_age + 1;
    cyc++;
  end

  task automatic drive();
    f_req  = (fq.size() > 0);
    f_addr = f_req ? 15'(fq[0]) : 15'd0;
    l_req  = (lq.size() > 0);
    l_addr = l_req ? 15'(lq[0]) : 15'd0;
    s_req  = (sqa.size() > 0);
    s_addr = s_req ? 15'(sqa[0]) : 15'd0;
    s_data = s_req ? 16'(sqd[0]) : 16'd0;
  endtask

  // Requesters hold their request until the model says it was granted.
  task automatic adv();
    @(posedge clk);
    #1;
    if (mg_f) void'(fq.pop_front());
    if (mg_l) void'(lq.pop_front());
    if (mg_s) begin
      void'(sqa.pop_front());
      void'(sqd.pop_front());
    end
    drive();
  endtask

  initial begin
    drive();
    repeat (3) adv();
    rst = 1'b0;
    mem_init = 1'b0;

    // Fetch stream at one per cycle.
    for (int i = 0; i < 8; i++) fq.push_back(i);
    drive();
    @(negedge clk); chk("A_fgnt_t0", bus0.f_gnt, 1); chk("A_frv_t0", bus0.f_rvalid, 0); adv();
    @(negedge clk); chk("A_fgnt_t1", bus0.f_gnt, 1); chk("A_maddr_t1", bus0.mem_addr, 1); adv();
    @(negedge clk); chk("A_frv_t2", bus0.f_rvalid, 1); chk("A_frd_t2", bus0.f_rdata, 16'hA000);
                    chk("A_frv3_t2", bus1.f_rvalid, 0); adv();
    @(negedge clk); chk("A_frd3_t3", bus1.f_rdata, 16'hA000); chk("A_frd_t3", bus0.f_rdata, 16'hA001); adv();
    repeat (10) adv();

    // All three at once; load reads back the store.
    sqa.push_back(5); sqd.push_back(16'hBEEF); lq.push_back(5); fq.push_back(100);
    drive();
    @(negedge clk); chk("B_sgnt_c0", bus0.s_gnt, 1); chk("B_lgnt_c0", bus0.l_gnt, 0);
                    chk("B_fgnt_c0", bus0.f_gnt, 0); chk("B_wdata_c0", bus0.mem_wdata, 16'hBEEF); adv();
    @(negedge clk); chk("B_lgnt_c1", bus0.l_gnt, 1); chk("B_fgnt_c1", bus0.f_gnt, 0);
                    chk("B_maddr_c1", bus0.mem_addr, 5); adv();
    @(negedge clk); chk("B_fgnt_c2", bus0.f_gnt, 1); chk("B_starved_c2", bus0.starved, 0); adv();
    @(negedge clk); chk("B_lrv_c3", bus0.l_rvalid, 1); chk("B_lrd_c3", bus0.l_rdata, 16'hBEEF); adv();
    repeat (8) adv();

    // Store/load pressure starves fetch.
    for (int i = 0; i < 6; i++) begin
      sqa.push_back(16 + i); sqd.push_back(16'h1000 + i); lq.push_back(16 + i);
    end
    fq.push_back(60);
    drive();
    @(negedge clk); chk("C_sgnt_c0", bus0.s_gnt, 1); chk("C_starved_c0", bus0.starved, 0); adv();
    @(negedge clk); chk("C_fgnt_c1", bus0.f_gnt, 0); adv();
    @(negedge clk); chk("C_starved_c2", bus0.starved, 0); chk("C_fgnt_c2", bus0.f_gnt, 0); adv();
    @(negedge clk); chk("C_starved_c3", bus0.starved, 1); chk("C_fgnt_c3", bus0.f_gnt, 1);
                    chk("C_sgnt_c3", bus0.s_gnt, 0); chk("C_maddr_c3", bus0.mem_addr, 60); adv();
    @(negedge clk); chk("C_starved_c4", bus0.starved, 0); chk("C_sgnt_c4", bus0.s_gnt, 1); adv();
    repeat (14) adv();

    // Reset with two reads in flight.
    lq.push_back(30); fq.push_back(31);
    drive();
    @(negedge clk); chk("D_lgnt_c0", bus0.l_gnt, 1); adv();
    @(negedge clk); chk("D_fgnt_c1", bus0.f_gnt, 1); adv();
    rst = 1'b1;
    fq.push_back(40);
    drive();
    @(negedge clk); chk("D_fgnt_c2", bus0.f_gnt, 0); chk("D_lrv_c2", bus0.l_rvalid, 0);
                    chk("D_wen_c2", bus0.mem_wen, 0); adv();
    rst = 1'b0;
    @(negedge clk); chk("D_frv_c3", bus0.f_rvalid, 0); chk("D_lrv3_c3", bus1.l_rvalid, 0);
                    chk("D_fgnt_c3", bus0.f_gnt, 1); adv();
    @(negedge clk); chk("D_frv_c4", bus0.f_rvalid, 0); chk("D_frv3_c4", bus1.f_rvalid, 0); adv();
    @(negedge clk); chk("D_frv_c5", bus0.f_rvalid, 1); chk("D_frd_c5", bus0.f_rdata, 16'hA028); adv();
    repeat (8) adv();

    // Alternating load/fetch; check routing on the latency-3 instance.
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        if (i % 2 == 0) lq.push_back(50 + i);
        else            fq.push_back(50 + i);
        drive();
      end
      @(negedge clk);
      if (i >= 3) begin
        chk($sformatf("E_lrv3_c%0d", i), bus1.l_rvalid, ((i - 3) % 2) == 0);
        chk($sformatf("E_frv3_c%0d", i), bus1.f_rvalid, ((i - 3) % 2) == 1);
        if ((i - 3) % 2 == 0) chk($sformatf("E_lrd3_c%0d", i), bus1.l_rdata, 16'hA032 + i - 3);
        else                  chk($sformatf("E_frd3_c%0d", i), bus1.f_rdata, 16'hA032 + i - 3);
      end
      adv();
    end
    repeat (4) adv();

    // Idle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("F_wen", bus0.mem_wen, 0); chk("F_maddr", bus0.mem_addr, 0);
      chk("F_starved", bus0.starved, 0); chk("F_sgnt", bus0.s_gnt, 0);
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported 16-bit word memory between three requesters: instruction fetch (read), data load (read) and data store (write).
- Issues at most one memory access per cycle.
- Routes read data back to the owning requester after a fixed latency.
- Prevents fetch starvation with a saturating age counter.
- Sits between the CPU pipeline stages and the memory, replacing the separate fetch and data ports.

Parameters:
- READ_LATENCY, 2, cycles from granted read to mem_rdata valid. Legal range is 1 to 4.
- STARVE_MAX, 3, number of consecutive denied fetch cycles before fetch is promoted to top priority. Legal range is 1 to 15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- f_req  in  1  fetch read request.
- f_addr  in  15  fetch word address, byte address bits [15:1].
- f_gnt  out  1  fetch request accepted this cycle.
- f_rvalid  out  1  f_rdata valid this cycle.
- f_rdata  out  16  fetch read data.
- l_req  in  1  load read request.
- l_addr  in  15  load word address.
- l_gnt  out  1  load request accepted this cycle.
- l_rvalid  out  1  l_rdata valid this cycle.
- l_rdata  out  16  load read data.
- s_req  in  1  store request.
- s_addr  in  15  store word address.
- s_data  in  16  store data.
- s_gnt  out  1  store accepted this cycle; the write occurs at this clock edge.
- mem_addr  out  15  memory address.
- mem_wen  out  1  memory write enable.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data, READ_LATENCY cycles after the address.
- starved  out  1  age counter is at STARVE_MAX, so fetch is promoted.

Behaviour:
- Grants are combinational from the req inputs and the registered age counter. They are one-hot or all zero.
- Requesters hold req and address until they see gnt in the same cycle.
- Normal priority is store, then load, then fetch.
- When starved=1, priority is fetch, then store, then load.
- While rst=1, all gnt, mem_wen and rvalid are 0. mem_addr is 0.
- Memory drive:
  - Store granted: mem_addr=s_addr, mem_wen=1, mem_wdata=s_data.
  - Load granted: mem_addr=l_addr, mem_wen=0.
  - Fetch granted: mem_addr=f_addr, mem_wen=0.
  - No grant: mem_addr=0, mem_wen=0, mem_wdata=0.
- Response tag pipe: a READ_LATENCY-deep shift register of 2-bit owner IDs (NONE, FETCH, LOAD).
  - Each cycle it shifts in the granted read's ID, or NONE.
  - Stores and idle cycles shift in NONE.
- Tag pipe output:
  - FETCH: f_rvalid=1 and f_rdata=mem_rdata.
  - LOAD: l_rvalid=1 and l_rdata=mem_rdata.
  - Data outputs are 0 whenever their rvalid is 0.
- Read latency is exactly READ_LATENCY cycles. Responses are returned in grant order, and back-to-back reads are sustained at one per cycle.
- Age counter, 4 bits:
  - Increments when f_req=1 and f_gnt=0, saturating at STARVE_MAX.
  - Clears to 0 on f_gnt=1 or f_req=0.
  - starved is (count==STARVE_MAX).
- Read-after-write ordering: accesses are never reordered. A load granted the cycle after a store to the same address sees the stored data, provided the memory completes writes at the clock edge.
- Reset values: counter=0, every tag-pipe entry=NONE, all outputs 0.
- Reset mid-operation drops in-flight reads: no rvalid is issued for them, including on the cycle rst deasserts.
- Requests seen while rst=1 are not granted and must be re-presented after reset.
- Simultaneous requests from all three requesters with starved=0 grant the store. A load and fetch left waiting cannot lose a later grant through counter wrap, because the counter saturates.

Decomposition:
- Package mem_arb_pkg holds the owner-ID constants (ID_NONE=2'd0, ID_FETCH=2'd1, ID_LOAD=2'd2), ADDR_W=15 and DATA_W=16.
- One sub-module, rsp_tag_pipe: a parameterised-depth shift register of IDs with synchronous clear and a registered output.
- Priority select, memory mux and age counter live in the top module.

Test Plan:
- Fetch only, f_req=1 every cycle with addr 0,1,2… -> f_gnt=1 each cycle; f_rvalid first high 2 cycles after the first grant; data matches memory; no bubbles.
- All three request at once, store addr 5 data 16'hBEEF, load addr 5 -> cycle 0 grants the store, cycle 1 grants the load, fetch is denied. l_rvalid at cycle 3 with l_rdata=16'hBEEF.
- Continuous store and load traffic with f_req held -> fetch denied 3 cycles, then starved=1; fetch granted on cycle 3; counter clears and starved drops the next cycle.
- rst pulsed for 1 cycle with two reads in flight -> no f_rvalid or l_rvalid for either; all outputs 0 during rst; the first post-reset grant behaves normally.
- Alternating load and fetch grants with READ_LATENCY=3 -> rvalid is routed to the correct requester 3 cycles after each grant; the other rvalid stays 0.
- Idle (no requests) -> mem_wen=0, mem_addr=0, all gnt and rvalid 0, counter stays 0.
